// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per channel a synchroniser, a counter debouncer and an edge-mode pulse.
// Define HOLD_REPEAT_EN to add auto-repeat pulses while a rising/both-mode channel is held high.
module input_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   in,
  input  logic [2*CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pulse
);

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_OFF  = 2'b11
  } edge_mode_e;

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (CHANNELS < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("input_conditioner: parameter out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [SYNC_STAGES-1:0] sync_d [CHANNELS];
  logic [CNT_W-1:0]       cnt_q  [CHANNELS];
  logic [CNT_W-1:0]       cnt_d  [CHANNELS];
  logic [CHANNELS-1:0]    level_q, level_d;
  logic [CHANNELS-1:0]    pulse_q, pulse_d;
  logic [CHANNELS-1:0]    accept;
  edge_mode_e             ch_mode [CHANNELS];

`ifdef HOLD_REPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q [CHANNELS];
  logic [REP_W-1:0] rep_d [CHANNELS];
`endif

  function automatic logic edge_match(edge_mode_e m, logic new_level);
    logic hit;
    case (m)
      EDGE_RISE: hit = new_level;
      EDGE_FALL: hit = ~new_level;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

  always_comb begin
    logic s_bit;
    s_bit   = 1'b0;
    level_d = level_q;
    pulse_d = '0;
    accept  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sync_d[i]  = {sync_q[i][SYNC_STAGES-2:0], in[i]};
      ch_mode[i] = edge_mode_e'(mode[2*i +: 2]);
      cnt_d[i]   = '0;
      s_bit      = sync_q[i][SYNC_STAGES-1];

      // The count only survives while the synchronised value keeps disagreeing with the level.
      if (s_bit != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          accept[i]  = 1'b1;
          level_d[i] = s_bit;
          pulse_d[i] = edge_match(ch_mode[i], s_bit);
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

`ifdef HOLD_REPEAT_EN
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      rep_d[i] = '0;
      // Accept pulses take precedence and restart the repeat interval.
      if (!accept[i] && level_q[i] &&
          (ch_mode[i] == EDGE_RISE || ch_mode[i] == EDGE_BOTH)) begin
        if (rep_q[i] == REP_LAST) begin
          pulse_d[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '{default: '0};
      cnt_q   <= '{default: '0};
      level_q <= '0;
      pulse_q <= '0;
`ifdef HOLD_REPEAT_EN
      rep_q   <= '{default: '0};
`endif
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
`ifdef HOLD_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule
